// File: rtl/iic_pkg.sv
// Shared types and constants for the IIC target and its line monitor.
package iic_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } iic_slave_state_e;

  localparam logic IIC_ACK  = 1'b0;
  localparam logic IIC_NACK = 1'b1;

  // Address byte is {7-bit address, rw}
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return addr_byte[7:1] == dev;
  endfunction

endpackage

// File: rtl/iic_slave_if.sv
// Bus-side and register-port signals of the IIC target, grouped with modports.
interface iic_slave_if;
  logic       en;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       sda_t;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       done;

  modport slave (
    input  en, scl_i, sda_i, reg_rdata,
    output sda_o, sda_t, reg_addr, reg_wdata, reg_we, reg_re, busy, done
  );

  modport master (
    output en, scl_i, sda_i, reg_rdata,
    input  sda_o, sda_t, reg_addr, reg_wdata, reg_we, reg_re, busy, done
  );
endinterface

// File: rtl/iic_line_sync.sv
// SCL/SDA synchronizer with SCL edge and START/STOP condition detection.
module iic_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Idle bus is high on both lines, so reset to 1 to avoid false edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda;
  assign stop     = scl_s & scl_d & ~sda_d & sda;

endmodule

// File: rtl/iic_slave.sv
// IIC target with register-pointer write/read access.
// Optional IIC_SLAVE_AUTOINC_EN: reg_addr post-increments after each written or read byte.
module iic_slave
  import iic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  DEV_ADDR    = 7'h51
) (
  input  logic         clk,
  input  logic         rst,
  iic_slave_if.slave   bus
);

  logic             sda_s;
  logic             scl_rise;
  logic             scl_fall;
  logic             start_det;
  logic             stop_det;
  logic [7:0]       rx_byte;

  iic_slave_state_e state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             sda_t_q, sda_t_d;
  logic [7:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             reg_we_q, reg_we_d;
  logic             reg_re_q, reg_re_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             matched_q, matched_d;
  logic             rw_q, rw_d;
  logic             ack_pend_q, ack_pend_d;
  logic             load_pend_q, load_pend_d;

  iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (bus.scl_i),
    .sda_i    (bus.sda_i),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det)
  );

  assign rx_byte = {shift_q[6:0], sda_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_t_d     = sda_t_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    matched_d   = matched_q;
    rw_d        = rw_q;
    ack_pend_d  = ack_pend_q;
    load_pend_d = 1'b0;

`ifdef IIC_SLAVE_AUTOINC_EN
    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;
`endif

    if (!bus.en) begin
      state_d    = S_IDLE;
      sda_t_d    = 1'b1;
      busy_d     = 1'b0;
      matched_d  = 1'b0;
      ack_pend_d = 1'b0;
    end else if (stop_det) begin
      state_d    = S_IDLE;
      sda_t_d    = 1'b1;
      busy_d     = 1'b0;
      done_d     = matched_q;
      matched_d  = 1'b0;
      ack_pend_d = 1'b0;
    end else if (start_det) begin
      state_d    = S_ADDR;
      bit_cnt_d  = '0;
      sda_t_d    = 1'b1;
      busy_d     = 1'b1;
      matched_d  = 1'b0;
      ack_pend_d = 1'b0;
    end else if (load_pend_q) begin
      // reg_rdata is valid while reg_re is high; first bit goes out right away
      shift_d   = bus.reg_rdata;
      sda_t_d   = bus.reg_rdata[7];
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        // Byte-receive states: shift on rise, enter ACK phase on the fall after bit 8
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_pend_d = 1'b1;
              if (state_q == S_ADDR) begin
                if (addr_match(rx_byte, DEV_ADDR)) begin
                  matched_d = 1'b1;
                  rw_d      = rx_byte[0];
                end else begin
                  state_d    = S_WAIT_STOP;
                  ack_pend_d = 1'b0;
                end
              end else if (state_q == S_REG) begin
                reg_addr_d = rx_byte;
              end else begin
                reg_wdata_d = rx_byte;
                reg_we_d    = 1'b1;
              end
            end
          end else if (scl_fall && ack_pend_q) begin
            ack_pend_d = 1'b0;
            sda_t_d    = IIC_ACK;
            case (state_q)
              S_ADDR:  state_d = S_ADDR_ACK;
              S_REG:   state_d = S_REG_ACK;
              default: state_d = S_WDATA_ACK;
            endcase
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d     = S_RDATA;
              reg_re_d    = 1'b1;
              load_pend_d = 1'b1;
            end else begin
              state_d = S_REG;
              sda_t_d = 1'b1;
            end
          end
        end
        S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_d   = S_WDATA;
            sda_t_d   = 1'b1;
            bit_cnt_d = '0;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) ack_pend_d = 1'b1;
          end else if (scl_fall) begin
            if (ack_pend_q) begin
              ack_pend_d = 1'b0;
              sda_t_d    = 1'b1;
              state_d    = S_RDATA_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sda_t_d = shift_q[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
`ifdef IIC_SLAVE_AUTOINC_EN
            reg_addr_d = reg_addr_q + 8'd1;
`endif
            if (sda_s == IIC_NACK) state_d = S_WAIT_STOP;
            else ack_pend_d = 1'b1;
          end else if (scl_fall && ack_pend_q) begin
            ack_pend_d  = 1'b0;
            reg_re_d    = 1'b1;
            load_pend_d = 1'b1;
            state_d     = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sda_t_q     <= 1'b1;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      matched_q   <= 1'b0;
      rw_q        <= 1'b0;
      ack_pend_q  <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_t_q     <= sda_t_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      matched_q   <= matched_d;
      rw_q        <= rw_d;
      ack_pend_q  <= ack_pend_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign bus.sda_o     = 1'b0;
  assign bus.sda_t     = sda_t_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_iic_slave.sv
// Bench for iic_slave: bit-banged IIC master, register bank, and expected-value model.
module tb_iic_slave;
  import iic_pkg::*;

  localparam int Q = 80;  // quarter SCL period

  logic clk;
  logic rst;
  logic m_scl;
  logic m_sda;
  int   checks = 0;
  int   errors = 0;
  int   re_cnt = 0;
  int   done_cnt = 0;

  logic [7:0] mem [256];
  logic [7:0] model_mem [256];
  logic [7:0] wbuf [4];
  logic [7:0] we_addr_q [$];
  logic [7:0] we_data_q [$];

  iic_slave_if bus ();

  iic_slave #(.SYNC_STAGES(2), .DEV_ADDR(7'h51)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.scl_i     = m_scl;
  assign bus.sda_i     = m_sda & (bus.sda_t ? 1'b1 : bus.sda_o);
  assign bus.reg_rdata = mem[bus.reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.reg_we) begin
      mem[bus.reg_addr] <= bus.reg_wdata;
      we_addr_q.push_back(bus.reg_addr);
      we_data_q.push_back(bus.reg_wdata);
    end
    if (bus.reg_re) re_cnt <= re_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] exp_addr(input logic [7:0] p, input int i);
`ifdef IIC_SLAVE_AUTOINC_EN
    return p + 8'(i);
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input logic b, output logic r);
    m_sda = b;
    #(Q) m_scl = 1'b1;
    #(Q) r = bus.sda_i;
    #(Q) m_scl = 1'b0;
    #(Q);
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    #(Q) m_scl = 1'b1;
    #(Q) m_sda = 1'b0;
    #(Q) m_scl = 1'b0;
    #(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    #(Q) m_scl = 1'b1;
    #(Q) m_sda = 1'b1;
    #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clk_bit(nack, r);
  endtask

  task automatic do_write(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] ea;
    int base, d0;
    base = we_addr_q.size();
    d0 = done_cnt;
    bus_start();
    check("busy_after_start", bus.busy, 1);
    write_byte({7'h51, 1'b0}, a);
    check("wr_addr_ack", a, IIC_ACK);
    write_byte(ptr, a);
    check("wr_ptr_ack", a, IIC_ACK);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a);
      check("wr_data_ack", a, IIC_ACK);
    end
    bus_stop();
    #100;
    check("we_count", we_addr_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      ea = exp_addr(ptr, i);
      check("we_addr", we_addr_q[base+i], ea);
      check("we_data", we_data_q[base+i], wbuf[i]);
      model_mem[ea] = wbuf[i];
    end
    check("done_after_write", done_cnt - d0, 1);
    check("busy_after_stop", bus.busy, 0);
  endtask

  task automatic do_read(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] d;
    int r0, d0;
    r0 = re_cnt;
    d0 = done_cnt;
    bus_start();
    write_byte({7'h51, 1'b0}, a);
    check("rd_waddr_ack", a, IIC_ACK);
    write_byte(ptr, a);
    check("rd_ptr_ack", a, IIC_ACK);
    bus_start();
    write_byte({7'h51, 1'b1}, a);
    check("rd_raddr_ack", a, IIC_ACK);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check("rd_data", d, model_mem[exp_addr(ptr, i)]);
    end
    check("rd_sda_released", bus.sda_t, 1);
    bus_stop();
    #100;
    check("re_count", re_cnt - r0, n);
    check("done_after_read", done_cnt - d0, 1);
  endtask

  initial begin
    logic a, r, ok;
    int w0, r0, d0;
    rst = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    bus.en = 1'b1;
    #22;
    check("rst_sda_t", bus.sda_t, 1);
    check("rst_sda_o", bus.sda_o, 0);
    check("rst_reg_addr", bus.reg_addr, 0);
    check("rst_reg_wdata", bus.reg_wdata, 0);
    check("rst_reg_we", bus.reg_we, 0);
    check("rst_reg_re", bus.reg_re, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    #20;

    // Basic single write
    wbuf[0] = 8'h0F;
    do_write(8'h02, 1);

    // Wrong address: NACK, no side effects
    w0 = we_addr_q.size(); r0 = re_cnt; d0 = done_cnt;
    bus_start();
    write_byte(8'hA4, a);
    check("bad_addr_nack", a, IIC_NACK);
    write_byte(8'h02, a);
    check("bad_addr_ptr_nack", a, IIC_NACK);
    check("bad_addr_busy", bus.busy, 1);
    bus_stop();
    #100;
    check("bad_addr_no_we", we_addr_q.size() - w0, 0);
    check("bad_addr_no_re", re_cnt - r0, 0);
    check("bad_addr_no_done", done_cnt - d0, 0);
    check("bad_addr_busy_stop", bus.busy, 0);

    // Pointer write, repeated START, read with master NACK
    wbuf[0] = 8'hA5;
    do_write(8'h02, 1);
    do_read(8'h02, 1);

    // Burst writes and pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(8'h10, 3);
    do_read(8'h10, 3);
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    do_write(8'hFF, 2);

    // STOP mid-byte discards the partial byte
    w0 = we_addr_q.size(); d0 = done_cnt;
    bus_start();
    write_byte({7'h51, 1'b0}, a);
    write_byte(8'h20, a);
    check("abort_ptr_ack", a, IIC_ACK);
    clk_bit(1'b1, r); clk_bit(1'b1, r); clk_bit(1'b0, r); clk_bit(1'b0, r);
    bus_stop();
    #100;
    check("abort_no_we", we_addr_q.size() - w0, 0);
    check("abort_sda_t", bus.sda_t, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_done", done_cnt - d0, 1);
    wbuf[0] = 8'h77;
    do_write(8'h20, 1);

    // en dropped mid-transaction: abort without done
    w0 = we_addr_q.size(); d0 = done_cnt;
    bus_start();
    write_byte({7'h51, 1'b0}, a);
    bus.en = 1'b0;
    #30;
    check("en_off_busy", bus.busy, 0);
    check("en_off_sda_t", bus.sda_t, 1);
    bus.en = 1'b1;
    bus_stop();
    #100;
    check("en_off_no_done", done_cnt - d0, 0);
    check("en_off_no_we", we_addr_q.size() - w0, 0);

    // Reset while the target drives ACK
    d0 = done_cnt;
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = {7'h51, 1'b0};
      clk_bit(ab[i], r);
    end
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (bus.sda_t == 1'b0) ok = 1'b1;
      else #10;
    end
    check("ack_driven_before_rst", ok, 1);
    rst = 1'b1;
    #1;
    check("midrst_sda_t", bus.sda_t, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_reg_addr", bus.reg_addr, 0);
    check("midrst_reg_wdata", bus.reg_wdata, 0);
    check("midrst_we_re", {bus.reg_we, bus.reg_re, bus.done}, 0);
    #9 rst = 1'b0;
    #(Q);
    bus_stop();
    #100;
    check("midrst_no_done", done_cnt - d0, 0);
    wbuf[0] = 8'h3C;
    do_write(8'h02, 1);
    do_read(8'h02, 1);

    // Randomized write/readback
    for (int it = 0; it < 6; it++) begin
      logic [7:0] p;
      int n;
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      do_write(p, n);
      do_read(p, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
